axi_hp_wr_sched: RTL and testbench
==================================

Name: axi_hp_wr_sched

Overview:
Round-robin scheduler that shares one 64-bit AXI_HP write port among NUM_CHN burst requesters.
- Each requester holds a complete burst in its own buffer and raises a request.
- The block grants one requester, issues the AW transfer, then streams that requester's data on W.
- It counts outstanding bursts against an issue cap and routes each B response back to its requester as a done pulse.

Parameters:
NUM_CHN, 4, number of requesters (2..8); also sets the AXI ID space.
MAX_OUTSTANDING, 8, maximum bursts with AW accepted but no B response yet (1..15).

Ports:
aclk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
chn_req  in  NUM_CHN  requester i has a full burst buffered.
chn_addr  in  32*NUM_CHN  start byte address of requester i's burst; 8-byte aligned.
chn_len  in  4*NUM_CHN  awlen of requester i's burst (beats-1).
chn_wdata  in  64*NUM_CHN  current head word of requester i's buffer (prefetched).
chn_grant  out  NUM_CHN  one-cycle pulse: requester i's burst accepted.
chn_rd  out  NUM_CHN  pop strobe to requester i's buffer.
chn_done  out  NUM_CHN  one-cycle pulse: B response received for requester i.
awaddr  out  32  AXI write address.
awvalid  out  1  AXI.
awready  in  1  AXI.
awid  out  6  requester index, zero-extended.
awlen  out  4  AXI.
awsize  out  3  constant 3'h3.
awburst  out  2  constant 2'b01 (INCR).
wdata  out  64  AXI.
wvalid  out  1  AXI.
wready  in  1  AXI.
wid  out  6  equals awid of the current burst.
wlast  out  1  AXI.
wstrb  out  8  constant 8'hff.
bvalid  in  1  AXI.
bready  out  1  AXI.
bid  in  6  AXI.
bresp  in  2  AXI.
outstanding  out  4  bursts awaiting B response.
err_bresp  out  1  sticky: a nonzero bresp was seen.

Behaviour:
- Reset (rst high at a clock edge): after that edge, state=IDLE; awvalid, wvalid, wlast, chn_grant, chn_rd, chn_done, outstanding and err_bresp are all 0. The RR pointer is set so the next grant starts at channel 0. Reset mid-burst abandons the burst; no done pulses are generated for it.
- bready is tied to 1; the block never back-pressures B.
- FSM states and transitions:
  - IDLE → ADDR when any chn_req is set and outstanding < MAX_OUTSTANDING. Arbitration is combinational: round-robin starting at (last granted+1) mod NUM_CHN.
  - On that edge the block registers: sel, awaddr=chn_addr[sel], awlen=chn_len[sel], awid=wid=sel, beat=0. It asserts awvalid, and chn_grant[sel] pulses for exactly this first ADDR cycle.
  - ADDR: awvalid holds with stable fields until awready. On the awvalid&&awready edge → DATA, awvalid drops, outstanding increments.
  - DATA: wvalid=1; wdata=chn_wdata[sel] combinationally; chn_rd[sel]=wvalid&&wready; wlast=(beat==awlen).
  - On each W handshake beat increments (4-bit). On the handshake with wlast → IDLE, so a new grant is possible on the following edge.
  - With wready low, beat, wdata source and chn_rd hold: chn_rd=0.
- Requester rules:
  - Deassert chn_req by the cycle after chn_grant unless another burst is ready. The FSM does not resample requests until it is back in IDLE (at least 2 cycles later).
  - chn_addr and chn_len must be stable from request until grant.
- Outstanding count:
  - +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING because issue is blocked in IDLE.
  - A B handshake with outstanding==0 is ignored; the count saturates at 0.
- B routing: on bvalid, chn_done[bid[2:0]] pulses the next cycle (registered). A bid ≥ NUM_CHN produces no pulse. bresp≠0 sets err_bresp, which holds until rst.
- Ordering: AW and W are strictly serialized per burst; W never starts before its AW is accepted. One burst is in flight on W at a time.

Test Plan:
1. Single burst: chn_req[0], addr 0x1000, len 3 → awaddr=0x1000, awlen=3, awid=0. Then 4 W beats with wid=0, wlast on beat 4, chn_rd[0] pulsed 4 times. bid=0 → chn_done[0] pulse; outstanding goes 0→1→0.
2. Round-robin: last grant=1, all 4 requests high and held → grant order 2,3,0,1, each burst's wdata taken from the granted channel.
3. Issue cap: MAX_OUTSTANDING=2, no bvalid → 2 bursts issued, 3rd request waits in IDLE with awvalid=0. One B response → 3rd AW issued the next cycle.
4. Back-pressure: wready low for 3 cycles mid-burst (len 7) → beat frozen, chn_rd=0, wdata stable; total beats still 8, single wlast.
5. Count edge cases: AW and B handshakes in the same cycle → outstanding unchanged. bresp=2'b10 → err_bresp=1, still 1 after later OKAY responses.
6. Reset mid-DATA: rst in beat 2 → next cycle wvalid=0, awvalid=0, outstanding=0, IDLE. A new request then issues normally starting from channel 0.

Source files
------------

// File: rtl/axi_hp_wr_sched.sv
// Round-robin scheduler sharing one 64-bit AXI_HP write port among NUM_CHN burst requesters.
// AW and W are serialized per burst; issue stalls in IDLE at the outstanding cap; B never back-pressured.
module axi_hp_wr_sched #(
  parameter int NUM_CHN         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic [NUM_CHN-1:0]    chn_req,
  input  logic [32*NUM_CHN-1:0] chn_addr,
  input  logic [4*NUM_CHN-1:0]  chn_len,
  input  logic [64*NUM_CHN-1:0] chn_wdata,
  output logic [NUM_CHN-1:0]    chn_grant,
  output logic [NUM_CHN-1:0]    chn_rd,
  output logic [NUM_CHN-1:0]    chn_done,
  output logic [31:0]           awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [5:0]            awid,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [63:0]           wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [5:0]            wid,
  output logic                  wlast,
  output logic [7:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [5:0]            bid,
  input  logic [1:0]            bresp,
  output logic [3:0]            outstanding,
  output logic                  err_bresp
);
  localparam int              SELW     = $clog2(NUM_CHN);
  localparam logic [3:0]      MAX_OS   = 4'(MAX_OUTSTANDING);
  localparam logic [SELW-1:0] LAST_CHN = SELW'(NUM_CHN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state;
  logic [SELW-1:0] sel;
  logic [SELW-1:0] last_grant;
  logic [SELW-1:0] arb_sel;
  logic [SELW-1:0] arb_cand;
  logic            arb_found;
  logic [3:0]      beat;
  logic            aw_hs;
  logic            b_hs;

  logic [31:0] addr_a  [NUM_CHN];
  logic [3:0]  len_a   [NUM_CHN];
  logic [63:0] wdata_a [NUM_CHN];

  for (genvar g = 0; g < NUM_CHN; g++) begin : g_unpack
    assign addr_a[g]  = chn_addr[32*g +: 32];
    assign len_a[g]   = chn_len[4*g +: 4];
    assign wdata_a[g] = chn_wdata[64*g +: 64];
  end

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_cand  = '0;
    for (int i = 1; i <= NUM_CHN; i++) begin
      arb_cand = SELW'((int'(last_grant) + i) % NUM_CHN);
      if (!arb_found && chn_req[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
  end

  assign aw_hs   = awvalid && awready;
  assign b_hs    = bvalid;
  assign bready  = 1'b1;
  assign awsize  = 3'h3;
  assign awburst = 2'b01;
  assign wstrb   = 8'hff;
  assign awid    = 6'(sel);
  assign wid     = 6'(sel);
  assign wdata   = wdata_a[sel];
  assign wlast   = wvalid && (beat == awlen);

  always_comb begin
    chn_rd = '0;
    if (wvalid && wready) chn_rd[sel] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      last_grant  <= LAST_CHN;
      beat        <= '0;
      awaddr      <= '0;
      awlen       <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      chn_grant   <= '0;
      chn_done    <= '0;
      outstanding <= '0;
      err_bresp   <= 1'b0;
    end else begin
      chn_grant <= '0;
      case (state)
        IDLE: begin
          if (arb_found && (outstanding < MAX_OS)) begin
            state               <= ADDR;
            sel                 <= arb_sel;
            last_grant          <= arb_sel;
            awaddr              <= addr_a[arb_sel];
            awlen               <= len_a[arb_sel];
            beat                <= '0;
            awvalid             <= 1'b1;
            chn_grant[arb_sel]  <= 1'b1;
          end
        end
        ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (wready) begin
            beat <= beat + 4'd1;
            if (beat == awlen) begin
              wvalid <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A B response with nothing outstanding is dropped rather than wrapping the count.
      if (aw_hs && !b_hs)
        outstanding <= outstanding + 4'd1;
      else if (!aw_hs && b_hs && (outstanding != 4'd0))
        outstanding <= outstanding - 4'd1;

      chn_done <= '0;
      if (b_hs && (bid < 6'(NUM_CHN))) chn_done[bid[SELW-1:0]] <= 1'b1;
      if (b_hs && (bresp != 2'b00)) err_bresp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_hp_wr_sched.sv
// Scoreboard bench for axi_hp_wr_sched: stimulus pushes expected AW/W/done items, a negedge monitor pops and compares.
module tb_axi_hp_wr_sched;
  localparam int N    = 4;
  localparam int MAXO = 2;

  logic            aclk = 1'b0;
  logic            rst  = 1'b1;
  logic [N-1:0]    chn_req = '0;
  logic [32*N-1:0] chn_addr = '0;
  logic [4*N-1:0]  chn_len = '0;
  logic [64*N-1:0] chn_wdata;
  logic [N-1:0]    chn_grant, chn_rd, chn_done;
  logic [31:0]     awaddr;
  logic            awvalid;
  logic            awready = 1'b1;
  logic [5:0]      awid;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [63:0]     wdata;
  logic            wvalid;
  logic            wready = 1'b1;
  logic [5:0]      wid;
  logic            wlast;
  logic [7:0]      wstrb;
  logic            bvalid = 1'b0;
  logic            bready;
  logic [5:0]      bid = '0;
  logic [1:0]      bresp = '0;
  logic [3:0]      outstanding;
  logic            err_bresp;

  axi_hp_wr_sched #(.NUM_CHN(N), .MAX_OUTSTANDING(MAXO)) dut (
    .aclk(aclk), .rst(rst), .chn_req(chn_req), .chn_addr(chn_addr), .chn_len(chn_len),
    .chn_wdata(chn_wdata), .chn_grant(chn_grant), .chn_rd(chn_rd), .chn_done(chn_done),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .wid(wid), .wlast(wlast), .wstrb(wstrb), .bvalid(bvalid), .bready(bready), .bid(bid),
    .bresp(bresp), .outstanding(outstanding), .err_bresp(err_bresp)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] addr; logic [3:0] len; logic [5:0] id; } aw_t;
  typedef struct { logic [63:0] data; logic [5:0] id; logic last; } w_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  int  done_q[$];
  int  total = 0;
  int  bad = 0;
  int  rd_cnt [N] = '{default: 0};
  int  exp_pop [N] = '{default: 0};
  aw_t m_aw;
  w_t  m_w;
  int  m_d;
  int  k0;

  // Each requester's head word encodes its channel and how many words it has popped.
  function automatic logic [63:0] pat(input int ch, input int k);
    return {16'hD47A, 8'(ch), 8'h5C, 32'(k)};
  endfunction

  function automatic logic [N-1:0] onehot(input int ch);
    return N'(1) << ch;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_src
    assign chn_wdata[64*g +: 64] = pat(g, rd_cnt[g]);
  end

  always @(posedge aclk)
    for (int i = 0; i < N; i++)
      if (chn_rd[i] === 1'b1) rd_cnt[i] <= rd_cnt[i] + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT output with no expected item queued", name);
  endtask

  always @(negedge aclk) begin
    if (!rst) begin
      if (awvalid && awready) begin
        if (aw_q.size() == 0) fail_now("aw_unexpected");
        else begin
          m_aw = aw_q.pop_front();
          chk("awaddr", awaddr, m_aw.addr);
          chk("awlen", awlen, m_aw.len);
          chk("awid", awid, m_aw.id);
          chk("awsize", awsize, 3'h3);
          chk("awburst", awburst, 2'b01);
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) fail_now("w_unexpected");
        else begin
          m_w = w_q.pop_front();
          chk("wdata", wdata, m_w.data);
          chk("wid", wid, m_w.id);
          chk("wlast", wlast, m_w.last);
          chk("wstrb", wstrb, 8'hff);
          chk("chn_rd", chn_rd, onehot(int'(m_w.id)));
        end
      end
      if (chn_done != '0) begin
        if (done_q.size() == 0) fail_now("done_unexpected");
        else begin
          m_d = done_q.pop_front();
          chk("chn_done", chn_done, onehot(m_d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (!rst && chn_grant != '0) begin
      chk("grant_has_req", chn_req & chn_grant, chn_grant);
      chn_req = chn_req & ~chn_grant;
    end
  endtask

  task automatic req_burst(input int ch, input logic [31:0] addr, input logic [3:0] len);
    chn_addr[32*ch +: 32] = addr;
    chn_len[4*ch +: 4]    = len;
    chn_req[ch]           = 1'b1;
  endtask

  task automatic exp_burst(input int ch, input logic [31:0] addr, input logic [3:0] len);
    aw_q.push_back('{addr, len, 6'(ch)});
    for (int b = 0; b <= int'(len); b++) begin
      w_q.push_back('{pat(ch, exp_pop[ch]), 6'(ch), b == int'(len)});
      exp_pop[ch]++;
    end
  endtask

  task automatic send_b(input int id, input logic [1:0] resp);
    bvalid = 1'b1;
    bid    = 6'(id);
    bresp  = resp;
    if (id < N) done_q.push_back(id);
    tick();
    bvalid = 1'b0;
    bid    = '0;
    bresp  = '0;
  endtask

  task automatic wait_aw_left(input int n);
    for (int c = 0; c < 300 && aw_q.size() != n; c++) tick();
    chk("wait_aw_left", aw_q.size(), n);
  endtask

  task automatic wait_w_left(input int n);
    for (int c = 0; c < 300 && w_q.size() != n; c++) tick();
    chk("wait_w_left", w_q.size(), n);
  endtask

  task automatic wait_wvalid();
    for (int c = 0; c < 100 && wvalid !== 1'b1; c++) tick();
    chk("wait_wvalid", wvalid, 1'b1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_grant", chn_grant, 4'h0);
    chk("rst_rd", chn_rd, 4'h0);
    chk("rst_done", chn_done, 4'h0);
    chk("rst_outstanding", outstanding, 4'd0);
    chk("rst_err", err_bresp, 1'b0);
    chk("bready", bready, 1'b1);
    rst = 1'b0;

    // Single burst on channel 0
    req_burst(0, 32'h1000, 4'd3);
    exp_burst(0, 32'h1000, 4'd3);
    wait_w_left(0);
    chk("t1_outstanding_1", outstanding, 4'd1);
    chk("t1_pops", rd_cnt[0], 4);
    send_b(0, 2'b00);
    chk("t1_outstanding_0", outstanding, 4'd0);

    // Leave the round-robin pointer on channel 1
    req_burst(1, 32'h2000, 4'd0);
    exp_burst(1, 32'h2000, 4'd0);
    wait_w_left(0);
    send_b(1, 2'b00);

    // All four request: order 2,3,0,1; cap of 2 blocks the third
    for (int ch = 0; ch < N; ch++) req_burst(ch, 32'h3000 + 32'(ch) * 32'h100, 4'd1);
    exp_burst(2, 32'h3200, 4'd1);
    exp_burst(3, 32'h3300, 4'd1);
    exp_burst(0, 32'h3000, 4'd1);
    exp_burst(1, 32'h3100, 4'd1);
    wait_aw_left(2);
    wait_w_left(4);
    chk("cap_outstanding", outstanding, 4'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("cap_awvalid_low", awvalid, 1'b0);
    end
    chk("cap_aw_pending", aw_q.size(), 2);
    send_b(2, 2'b00);
    chk("cap_after_b_out", outstanding, 4'd1);
    chk("cap_after_b_aw", awvalid, 1'b0);
    tick();
    chk("cap_reissue_aw", awvalid, 1'b1);
    chk("cap_reissue_grant", chn_grant, 4'b0001);
    // AW and B handshakes on the same edge, with an error response
    send_b(3, 2'b10);
    chk("same_cycle_out", outstanding, 4'd1);
    chk("err_set", err_bresp, 1'b1);
    wait_aw_left(0);
    wait_w_left(0);
    chk("t2_outstanding_2", outstanding, 4'd2);
    send_b(0, 2'b00);
    send_b(1, 2'b00);
    chk("t2_outstanding_0", outstanding, 4'd0);
    chk("err_sticky", err_bresp, 1'b1);

    // Back-pressure mid-burst, len 7
    wready = 1'b0;
    k0 = exp_pop[2];
    req_burst(2, 32'h4000, 4'd7);
    exp_burst(2, 32'h4000, 4'd7);
    wait_wvalid();
    wready = 1'b1;
    tick();
    tick();
    tick();
    wready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_rd_low", chn_rd, 4'h0);
      chk("bp_wvalid", wvalid, 1'b1);
      chk("bp_wdata_hold", wdata, pat(2, k0 + 3));
    end
    wready = 1'b1;
    wait_w_left(0);
    chk("bp_total_beats", rd_cnt[2] - k0, 8);
    send_b(2, 2'b00);
    chk("bp_outstanding", outstanding, 4'd0);
    chk("err_sticky_2", err_bresp, 1'b1);

    // Reset in the middle of a burst
    wready = 1'b0;
    req_burst(1, 32'h5000, 4'd3);
    exp_burst(1, 32'h5000, 4'd3);
    wait_wvalid();
    wready = 1'b1;
    tick();
    tick();
    wready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_wlast", wlast, 1'b0);
    chk("mid_rst_outstanding", outstanding, 4'd0);
    chk("mid_rst_err", err_bresp, 1'b0);
    chk("mid_rst_beats_left", w_q.size(), 2);
    w_q.delete();
    exp_pop[1] = exp_pop[1] - 2;
    rst = 1'b0;
    wready = 1'b1;
    req_burst(3, 32'h6000, 4'd0);
    req_burst(0, 32'h7000, 4'd1);
    exp_burst(0, 32'h7000, 4'd1);
    exp_burst(3, 32'h6000, 4'd0);
    wait_aw_left(0);
    wait_w_left(0);
    chk("post_rst_outstanding", outstanding, 4'd2);
    send_b(0, 2'b00);
    send_b(3, 2'b00);
    send_b(5, 2'b00);
    chk("sat_outstanding", outstanding, 4'd0);

    tick();
    tick();
    chk("end_aw_q", aw_q.size(), 0);
    chk("end_w_q", w_q.size(), 0);
    chk("end_done_q", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
